// File: rtl/multiword_add_pkg.sv
// Shared FSM encodings for the slice-serial multiword adder.
// Imported by multiword_add_ctrl.
package multiword_add_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_ctrl_cla.sv
// N-bit carry-look-ahead adder used as the single slice adder.
// Ports: a, b (N bits), cin -> sum (N bits), cout.
module Carry_Look_Ahead_Adder_n_bit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is expanded as a flat sum of generate terms
  // gated by the propagate chain, rather than rippled.
  always_comb begin
    logic acc;
    logic pp;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Slice-serial W-bit adder: one N-bit CLA slice per RUN cycle.
// Ports: clk, rst (async high), start, a, b, cin -> busy, done,
// sum, cout; ovf only when MULTIWORD_ADD_OVF_EN is defined.
module multiword_add_ctrl
  import multiword_add_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef MULTIWORD_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int S  = W / N;
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  state_t         state;
  state_t         state_n;
  logic           accept;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           carry;
  logic [IW-1:0]  idx;
  logic           last;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   ss;
  logic           sc;

  assign sa   = a_r[idx*N +: N];
  assign sb   = b_r[idx*N +: N];
  assign last = (idx == IW'(S - 1));

  Carry_Look_Ahead_Adder_n_bit #(
    .N(N)
  ) u_cla (
    .a   (sa),
    .b   (sb),
    .cin (carry),
    .sum (ss),
    .cout(sc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      carry <= cin;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == RUN) begin
      sum[idx*N +: N] <= ss;
      carry           <= sc;
      idx             <= idx + IW'(1);
      if (last) cout  <= sc;
    end
  end

`ifdef MULTIWORD_ADD_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit:
  // s = a ^ b ^ c_in, so c_in = a ^ b ^ s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (state == RUN && last) begin
      ovf <= sc ^ (sa[N-1] ^ sb[N-1] ^ ss[N-1]);
    end
  end
`endif

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed and random checks of multiword_add_ctrl (N=4, W=16).
// Define MULTIWORD_ADD_OVF_EN to also exercise ovf.
module tb_multiword_add_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef MULTIWORD_ADD_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multiword_add_ctrl #(
    .N(N),
    .W(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef MULTIWORD_ADD_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Pulse start with operands, then wait (bounded) until done is
  // seen on a falling edge; cyc = falling edges after accept.
  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb,
                        input logic tc,
                        output int cyc,
                        output bit tmo);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    tmo = 1'b0;
    while (!done) begin
      if (cyc > 20) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, sum, cout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b want all 0",
               busy, done, sum, cout);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int bcnt;
    bit seen;
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
    n_checks++;
    if (bcnt !== 4 || !seen) begin
      n_fail++;
      $display("FAIL basic_busy_cycles got %0d done_seen=%0b want 4,1", bcnt, seen);
    end
    n_checks++;
    if (sum !== 16'h0100 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result got %b_%h want 0_0100", cout, sum);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse got done=%b busy=%b want 0,0", done, busy);
    end
    n_checks++;
    if (sum !== 16'h0100 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold got %b_%h want 0_0100", cout, sum);
    end
  endtask

  task automatic test_vectors();
    int cyc;
    bit tmo;
    run_op(16'hFFFF, 16'h0001, 1'b0, cyc, tmo);
    n_checks++;
    if (tmo || cyc != 5) begin
      n_fail++;
      $display("FAIL vec1_latency got %0d tmo=%0b want 5", cyc, tmo);
    end
    n_checks++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL vec1_result got %b_%h want 1_0000", cout, sum);
    end
    run_op(16'h1234, 16'h4321, 1'b1, cyc, tmo);
    n_checks++;
    if (tmo || sum !== 16'h5556 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL vec2_result got %b_%h tmo=%0b want 0_5556", cout, sum, tmo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    // held start and new operands must be ignored during RUN
    a = 16'hAAAA; b = 16'h5555;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen || sum !== 16'h2345 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first got %b_%h seen=%0b want 0_2345", cout, sum, seen);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept_in_done got busy=%b want 1", busy);
    end
    cyc = 1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!seen || cyc != 5) begin
      n_fail++;
      $display("FAIL b2b_latency got %0d seen=%0b want 5", cyc, seen);
    end
    n_checks++;
    if (sum !== 16'hFFFF || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second got %b_%h want 0_ffff", cout, sum);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit tmo;
    bit dseen;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || sum === 16'h0000) begin
      n_fail++;
      $display("FAIL abort_midrun got busy=%b sum=%h want 1,nonzero", busy, sum);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, sum, cout} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs got busy=%b done=%b sum=%h cout=%b want 0",
               busy, done, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    dseen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) dseen = 1'b1;
    end
    n_checks++;
    if (dseen) begin
      n_fail++;
      $display("FAIL abort_no_done got activity=1 want 0");
    end
    run_op(16'h8001, 16'h8001, 1'b0, cyc, tmo);
    n_checks++;
    if (tmo || sum !== 16'h0002 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_recover got %b_%h tmo=%0b want 1_0002", cout, sum, tmo);
    end
  endtask

`ifdef MULTIWORD_ADD_OVF_EN
  task automatic test_ovf();
    int cyc;
    bit tmo;
    run_op(16'h7FFF, 16'h0001, 1'b0, cyc, tmo);
    n_checks++;
    if (tmo || ovf !== 1'b1 || sum !== 16'h8000) begin
      n_fail++;
      $display("FAIL ovf_pos got ovf=%b sum=%h want 1,8000", ovf, sum);
    end
    run_op(16'hFFFF, 16'h0001, 1'b0, cyc, tmo);
    n_checks++;
    if (tmo || ovf !== 1'b0 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg got ovf=%b cout=%b want 0,1", ovf, cout);
    end
    run_op(16'h8000, 16'h8000, 1'b0, cyc, tmo);
    n_checks++;
    if (tmo || ovf !== 1'b1 || {cout, sum} !== 17'h10000) begin
      n_fail++;
      $display("FAIL ovf_minmin got ovf=%b %b_%h want 1,1_0000", ovf, cout, sum);
    end
  endtask
`endif

  task automatic test_random();
    int cyc;
    bit tmo;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   exp;
    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom());
      rb  = W'($urandom());
      rc  = 1'($urandom_range(0, 1));
      exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op(ra, rb, rc, cyc, tmo);
      n_checks++;
      if (tmo || {cout, sum} !== exp) begin
        n_fail++;
        $display("FAIL random_%0d %h+%h+%b got %h tmo=%0b want %h",
                 i, ra, rb, rc, {cout, sum}, tmo, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
`ifdef MULTIWORD_ADD_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: slice width of the carry-look-ahead adder instance.
REQ-002 SHALL have parameter W, default 16: total operand width; W SHALL be a multiple of N and W >= N.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an addition.
REQ-006 SHALL have ports a and b, input, W bits each: operands, sampled only on an accepted start.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, sampled only on an accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high while slices are being added.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 SHALL have port sum, output, W bits: registered result.
REQ-011 SHALL have port cout, output, 1 bit: registered final carry-out.

Function
REQ-012 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL be accepted: latch a, b and cin into internal registers, clear sum to 0, set slice index to 0, and enter RUN.
REQ-014 In RUN, each cycle SHALL add operand slice [idx*N +: N] of a and b plus the carry register through one N-bit adder, write the result to sum[idx*N +: N], store the adder carry-out in the carry register, and increment idx.
REQ-015 After the slice with idx = W/N-1 is written, the FSM SHALL enter DONE, and cout SHALL equal that slice's carry-out.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE, which is W/N+1 cycles after the accepting edge (5 cycles for the defaults).
REQ-017 DONE SHALL return to IDLE on the next edge unless start=1, in which case the new request SHALL be accepted (back-to-back operation).
REQ-018 busy SHALL be high only in RUN; start in RUN SHALL be ignored, with no effect on operands or progress.
REQ-019 sum and cout SHALL hold their values in IDLE and DONE until the next accepted start.
REQ-020 When W = N, RUN SHALL last exactly one cycle.
REQ-021 The carry register SHALL be internal and SHALL NOT be exposed.

Reset
REQ-022 While rst=1, the FSM SHALL be IDLE and busy, done, sum, cout, idx, the carry register and the operand registers SHALL all be 0, regardless of clk.
REQ-023 Asserting rst mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-024 With macro MULTIWORD_ADD_OVF_EN defined, the block SHALL add output ovf (1 bit): the signed two's-complement overflow of the W-bit result (carry into MSB XOR carry out of MSB), registered with cout, reset to 0, and cleared on accept.
REQ-025 Without MULTIWORD_ADD_OVF_EN, port ovf and its logic SHALL be absent.

Structure
REQ-026 FSM state encodings (IDLE=0, RUN=1, DONE=2) and the state width constant SHALL live in shared package multiword_add_pkg.
REQ-027 The block SHALL instantiate exactly one existing N-bit carry-look-ahead adder (Carry_Look_Ahead_Adder_n_bit) as its only sub-module; no other adder SHALL be inferred on the datapath.

Verification (N=4, W=16)
REQ-028 a=0x00FF, b=0x0001, cin=0, start pulse -> busy high for 4 cycles, then done for 1 cycle, sum=0x0100, cout=0.
REQ-029 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
REQ-030 Start accepted, then start=1 held through RUN with a=0xAAAA -> the first result is unaffected; the held start is accepted in DONE and a second result follows 5 cycles later.
REQ-031 Start accepted, then rst pulsed after 2 RUN cycles -> all outputs 0 immediately, no done pulse; a fresh operation then completes correctly.
REQ-032 With MULTIWORD_ADD_OVF_EN: 0x7FFF+0x0001 -> ovf=1, sum=0x8000; 0xFFFF+0x0001 -> ovf=0, cout=1.
REQ-033 Random a, b, cin across 1000 operations -> {cout,sum} equals a+b+cin each time done=1.
